// File: rtl/result_collector_pkg.sv
// Shared matrix-multiplier definitions: FP32 word width, elements per 2x2 result
// matrix, element index encoding and the result collector FSM states.
package result_collector_pkg;

  localparam int WORD_W  = 32;
  localparam int ELEMS   = 4;
  localparam int ENTRY_W = WORD_W * ELEMS;

  // Row-major element order of a 2x2 result matrix
  typedef enum logic [1:0] {
    IDX_C00 = 2'd0,
    IDX_C01 = 2'd1,
    IDX_C10 = 2'd2,
    IDX_C11 = 2'd3
  } elem_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/result_fifo.sv
// DEPTH x 128-bit synchronous FIFO of whole result matrices. The head entry is
// read combinationally so the collector can mux words out without extra latency.
module result_fifo
  import result_collector_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wr_data,
  output logic [ENTRY_W-1:0]       head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               full;
  logic               wr_en;
  logic               rd_en;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign rd_en = pop && (count_reg != '0);
  // A pop on the same edge frees the head slot, which is exactly where wr_ptr points when full
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && !wr_en;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/result_collector.sv
// Buffers 2x2 FP32 result matrices from the systolic array and streams them out
// one word per handshake in row-major order, with a sticky overflow flag.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_op,
  input  logic [31:0]            result_row00,
  input  logic [31:0]            result_row01,
  input  logic [31:0]            result_row10,
  input  logic [31:0]            result_row11,
  input  logic                   m_ready,
  input  logic                   clr_ovf,
  output logic [31:0]            m_data,
  output logic                   m_valid,
  output logic [1:0]             m_idx,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t             state_reg;
  logic               valid_reg;
  logic               last_reg;
  logic               ovf_reg;
  elem_idx_t          idx_reg;
  logic               hs;
  logic               pop;
  logic               drop;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head;
  logic [WORD_W-1:0]  words [ELEMS];

  assign entry_in = {result_row11, result_row10, result_row01, result_row00};
  assign hs       = valid_reg && m_ready;
  assign pop      = hs && (idx_reg == IDX_C11);

  result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (valid_op),
    .pop     (pop),
    .wr_data (entry_in),
    .head    (head),
    .count   (fifo_count),
    .drop    (drop)
  );

  for (genvar gi = 0; gi < ELEMS; gi++) begin : g_words
    assign words[gi] = head[gi*WORD_W +: WORD_W];
  end

  assign m_data = words[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      idx_reg   <= IDX_C00;
      last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fifo_count != '0) begin
            state_reg <= STREAM;
            valid_reg <= 1'b1;
            idx_reg   <= IDX_C00;
            last_reg  <= 1'b0;
          end
        end
        STREAM: begin
          if (hs) begin
            if (idx_reg == IDX_C11) begin
              idx_reg  <= IDX_C00;
              last_reg <= 1'b0;
              // A capture coinciding with a pop is always accepted, so it also keeps us streaming
              if ((fifo_count > CNT_W'(1)) || valid_op) begin
                state_reg <= STREAM;
                valid_reg <= 1'b1;
              end else begin
                state_reg <= IDLE;
                valid_reg <= 1'b0;
              end
            end else begin
              idx_reg  <= elem_idx_t'(idx_reg + 2'd1);
              last_reg <= (idx_reg == IDX_C10);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          idx_reg   <= IDX_C00;
          last_reg  <= 1'b0;
        end
      endcase
    end
  end

  // A dropped capture outranks a clear on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (clr_ovf) begin
      ovf_reg <= 1'b0;
    end
  end

  assign m_valid  = valid_reg;
  assign m_idx    = idx_reg;
  assign m_last   = last_reg;
  assign count    = fifo_count;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_result_collector;

  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   valid_op;
  logic [31:0]            r00, r01, r10, r11;
  logic                   m_ready;
  logic                   clr_ovf;
  logic [31:0]            m_data;
  logic                   m_valid;
  logic [1:0]             m_idx;
  logic                   m_last;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: matrices held, stream position within the head, sticky flag
  logic [127:0] mq[$];
  bit           exp_valid = 1'b0;
  int           exp_idx   = 0;
  bit           exp_ovf   = 1'b0;

  logic [31:0]  got[$];
  logic [127:0] mat_a, mat_1, mat_2, mat_3, mat_4;

  result_collector #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_op     (valid_op),
    .result_row00 (r00),
    .result_row01 (r01),
    .result_row10 (r10),
    .result_row11 (r11),
    .m_ready      (m_ready),
    .clr_ovf      (clr_ovf),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_idx        (m_idx),
    .m_last       (m_last),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] c00, c01, c10, c11);
    return {c11, c10, c01, c00};
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] m, input int i);
    return m[i*32 +: 32];
  endfunction

  // One model step per rising edge, from the inputs the DUT sees on that edge
  task automatic model_step();
    int  sz_before;
    bit  hs, pop, drop;
    sz_before = mq.size();
    hs   = exp_valid && m_ready;
    pop  = hs && (exp_idx == 3);
    drop = 1'b0;
    if (pop) void'(mq.pop_front());
    if (valid_op) begin
      if (sz_before < DEPTH || pop) mq.push_back(mk(r00, r01, r10, r11));
      else drop = 1'b1;
    end
    if (drop) exp_ovf = 1'b1;
    else if (clr_ovf) exp_ovf = 1'b0;
    if (!exp_valid) begin
      if (sz_before > 0) begin
        exp_valid = 1'b1;
        exp_idx   = 0;
      end
    end else if (hs) begin
      if (exp_idx == 3) begin
        exp_idx   = 0;
        exp_valid = (mq.size() > 0);
      end else begin
        exp_idx++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        exp_valid = 1'b0;
        exp_idx   = 0;
        exp_ovf   = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Compare process: outputs are checked on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
      end else begin
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("m_idx", 32'(m_idx), 32'(exp_idx));
        chk("m_last", 32'(m_last), 32'(exp_valid && exp_idx == 3));
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        if (exp_valid && mq.size() > 0) chk("m_data", m_data, word_of(mq[0], exp_idx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cap(input logic [127:0] m);
    valid_op = 1'b1;
    {r11, r10, r01, r00} = m;
    tick();
    valid_op = 1'b0;
  endtask

  task automatic drain(input int n);
    got.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 8 * n + 16 && got.size() < n; c++) begin
      if (m_valid) got.push_back(m_data);
      tick();
    end
    chk("drain_len", 32'(got.size()), 32'(n));
  endtask

  task automatic chk_seq(input string tag, input int n, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] m;
    logic [31:0]  w;
    for (int i = 0; i < n; i++) begin
      m = (i < 4) ? a : b;
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      chk(tag, w, word_of(m, i % 4));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_a = mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    mat_1 = mk(32'h7FC00001, 32'h00000001, 32'h80000000, 32'hFF800000);
    mat_2 = mk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    mat_3 = mk(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
    mat_4 = mk(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    valid_op = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    {r11, r10, r01, r00} = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_m_idx", 32'(m_idx), 32'(0));
    chk("reset_m_last", 32'(m_last), 32'(0));
    rst_n = 1'b1;
    tick();

    // Single matrix, m_ready held high
    m_ready = 1'b1;
    cap(mat_a);
    chk("single_count", 32'(count), 32'(1));
    chk("single_novalid", 32'(m_valid), 32'(0));
    tick();
    chk("single_valid", 32'(m_valid), 32'(1));
    chk("single_w0", m_data, 32'h3F800000);
    chk("single_last0", 32'(m_last), 32'(0));
    tick(); chk("single_w1", m_data, 32'h40000000);
    tick(); chk("single_w2", m_data, 32'h40400000);
    tick(); chk("single_w3", m_data, 32'h40800000);
    chk("single_last3", 32'(m_last), 32'(1));
    tick();
    chk("single_done", 32'(m_valid), 32'(0));
    chk("single_empty", 32'(count), 32'(0));

    // Backpressure at m_idx=1
    cap(mat_a);
    tick();
    tick();
    chk("bp_w1", m_data, 32'h40000000);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", m_data, 32'h40000000);
      chk("bp_hold_valid", 32'(m_valid), 32'(1));
      chk("bp_hold_idx", 32'(m_idx), 32'(1));
    end
    m_ready = 1'b1;
    tick();
    chk("bp_w2", m_data, 32'h40400000);
    tick(); tick();
    chk("bp_done", 32'(m_valid), 32'(0));

    // Overflow: third capture while full and stalled is dropped
    m_ready = 1'b0;
    cap(mat_1); cap(mat_2); cap(mat_3);
    chk("ovf_count", 32'(count), 32'(2));
    chk("ovf_flag", 32'(overflow), 32'(1));
    drain(8);
    chk_seq("ovf_drain", 8, mat_1, mat_2);
    chk("ovf_sticky", 32'(overflow), 32'(1));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'(0));

    // Full with a capture on the head's final handshake
    m_ready = 1'b0;
    cap(mat_1); cap(mat_2);
    m_ready = 1'b1;
    tick(); tick(); tick();
    chk("fp_at_last", 32'(m_idx), 32'(3));
    cap(mat_4);
    chk("fp_count", 32'(count), 32'(2));
    chk("fp_ovf", 32'(overflow), 32'(0));
    chk("fp_nobubble", 32'(m_valid), 32'(1));
    chk("fp_next_c00", m_data, 32'h11111111);
    drain(8);
    chk_seq("fp_drain", 8, mat_2, mat_4);

    // Back-to-back matrices with no idle cycle
    m_ready = 1'b0;
    cap(mat_3); cap(mat_4);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", 32'(m_valid), 32'(1));
      chk("b2b_data", m_data, word_of(i < 4 ? mat_3 : mat_4, i % 4));
      tick();
    end
    chk("b2b_done", 32'(m_valid), 32'(0));

    // Reset in the middle of a stream
    cap(mat_a);
    tick(); tick(); tick();
    chk("rst_mid_idx", 32'(m_idx), 32'(2));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(m_valid), 32'(0));
    chk("rst_mid_count", 32'(count), 32'(0));
    tick();
    rst_n = 1'b1;
    cap(mat_a);
    tick();
    chk("post_rst_c00", m_data, 32'h3F800000);
    chk("post_rst_idx", 32'(m_idx), 32'(0));
    drain(4);
    chk_seq("post_rst_drain", 4, mat_a, mat_a);

    // Random traffic, alternating stalled and flowing segments
    for (int seg = 0; seg < 10; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 20 : 80;
      for (int c = 0; c < 300; c++) begin
        valid_op = ($urandom_range(0, 99) < 35);
        r00 = $urandom; r01 = $urandom; r10 = $urandom; r11 = $urandom;
        m_ready = ($urandom_range(0, 99) < rdy_pct);
        clr_ovf = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    valid_op = 1'b0;
    clr_ovf  = 1'b0;
    m_ready  = 1'b1;
    repeat (20) tick();
    chk("final_empty", 32'(count), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of buffered 2x2 result matrices (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port valid_op  input  1  capture strobe from the systolic array; one-cycle pulse marks results valid.
REQ-005 SHALL have ports result_row00, result_row01, result_row10, result_row11  input  32 each  FP32 results of the 2x2 array.
REQ-006 SHALL have port m_ready  input  1  downstream accepts the current word.
REQ-007 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port m_data  output  32  current FP32 result word.
REQ-009 SHALL have port m_valid  output  1  m_data is valid.
REQ-010 SHALL have port m_idx  output  2  element index of m_data: 0=C00, 1=C01, 2=C10, 3=C11.
REQ-011 SHALL have port m_last  output  1  high with m_valid when m_idx==3.
REQ-012 SHALL have port count  output  clog2(DEPTH)+1  number of matrices held, including the one streaming.
REQ-013 SHALL have port overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-014 SHALL write all four results into the FIFO entry at wr_ptr as one entry on a rising edge with valid_op=1 when not full.
REQ-015 SHALL stream entries in capture order, row-major C00, C01, C10, C11, one word per m_valid&&m_ready handshake.
REQ-016 SHALL use FSM states IDLE (m_valid=0) and STREAM (m_valid=1).
REQ-017 SHALL move IDLE->STREAM on the edge after count becomes non-zero, so the first m_valid is seen one cycle after the capture edge.
REQ-018 SHALL, in STREAM, increment m_idx on each handshake and hold m_data, m_idx and m_valid stable while m_ready=0.
REQ-019 SHALL pop the head entry on the handshake with m_idx==3, reset m_idx to 0, and stay in STREAM if another entry remains (no bubble), otherwise go to IDLE.
REQ-020 SHALL take m_data combinationally from the head entry selected by the registered m_idx; m_valid, m_idx and m_last SHALL be registered.
REQ-021 SHALL, when full, drop a capture, leave the stored data unchanged and set overflow.
REQ-022 SHALL accept a capture when full if a pop occurs on the same edge, leaving count unchanged.
REQ-023 SHALL leave count unchanged on a simultaneous capture and pop when not full; otherwise count SHALL be +1 on capture and -1 on pop.
REQ-024 SHALL wrap pointers modulo DEPTH, with full/empty taken from count.
REQ-025 SHALL clear overflow when clr_ovf=1; a drop on the same edge SHALL win (overflow stays 1).
REQ-026 SHALL not interpret data values (pure storage; NaN and denormals are passed bit-exact).

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force IDLE, m_valid=0, m_idx=0, m_last=0, count=0, overflow=0, pointers=0.
REQ-028 SHALL discard all buffered and partially streamed matrices on reset mid-stream; data RAM contents need no reset.
REQ-029 SHALL ignore valid_op on the first edge after rst_n deasserts only if it coincides with the deassertion edge; normal operation SHALL resume from the next edge.

Structure
REQ-030 SHALL place the FP32 word width (32), elements per matrix (4) and the element index encoding in the shared matrix-multiplier package.
REQ-031 SHALL instantiate one sub-module, result_fifo: a DEPTH x 128-bit synchronous FIFO with count; the FSM and the word mux SHALL live in result_collector.

Verification
REQ-032 SHALL cover the single matrix case: one valid_op with C=0x3F800000, 0x40000000, 0x40400000, 0x40800000 and m_ready=1 -> m_valid rises the next cycle, the four words come out in 4 consecutive cycles, and m_last is high only on 0x40800000.
REQ-033 SHALL cover backpressure: m_ready=0 for 5 cycles at m_idx=1 -> m_data holds 0x40000000 and m_valid stays 1; after m_ready=1, 0x40400000 follows.
REQ-034 SHALL cover overflow: three valid_op with m_ready=0 (DEPTH=2) -> count=2, overflow=1, and drained data equals the first two matrices only.
REQ-035 SHALL cover the full-with-pop case: full, with a capture on the same edge as the final handshake of the head -> count stays 2, overflow stays 0, and the new matrix drains third.
REQ-036 SHALL cover back-to-back matrices: two queued matrices -> 8 words with no idle cycle between m_last and the next C00.
REQ-037 SHALL cover reset mid-stream: rst_n low at m_idx=2 -> m_valid=0 and count=0 immediately; a post-reset capture streams from C00.
